// File: rtl/adpll_ctrl_pkg.sv
// adpll_ctrl_pkg
// Shared definitions for the ADPLL multiplier/lock sequencer. The package
// holds the following items:
//   - the sequencer state encoding (3-bit enum);
//   - the multiplier code width;
//   - the multiplier code applied after reset, which the ADPLL bench shares;
//   - a helper that sizes a counter so it can hold its terminal count.
package adpll_ctrl_pkg;

  localparam int MULT_W = 3;

  localparam logic [MULT_W-1:0] DEFAULT_MULT_CODE = 3'd0;

  typedef enum logic [2:0] {
    ST_APPLY     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_CONFIRM   = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

  // Width needed for a counter that must be able to hold the value n itself.
  function automatic int cntWidth(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/adpll_ctrl_lock_sync.sv
// adpll_ctrl_lock_sync
// Two-flop synchronizer that brings the ADPLL LOCK indication into the
// REF_CLK domain. The output reads 0 while reset is asserted, so the
// sequencer never sees a stale lock right after reset.
// Ports:
//   i_clk   - REF_CLK
//   i_rst   - asynchronous active-high reset
//   i_async - raw LOCK from the ADPLL
//   o_sync  - LOCK as seen two REF_CLK edges later
module adpll_ctrl_lock_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  // The first stage may go metastable. Only the second stage is used downstream.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/adpll_ctrl.sv
// adpll_ctrl
// Multiplier-change and lock-supervision sequencer for the ADPLL.
// The block takes multiplier requests over a valid/ready handshake.
// For each request it performs these steps:
//   - pulses the ADPLL reset;
//   - waits for a stable LOCK;
//   - retries on timeout;
//   - relocks at the current multiplier when lock is lost in RUN.
// Ports:
//   i_ref_clk    - REF_CLK, sole clock (rising edge)
//   i_reset      - asynchronous active-high reset
//   i_req_valid  - request present
//   i_req_mult   - requested multiplier code
//   o_req_ready  - a request can be accepted this cycle
//   i_lock       - ADPLL lock (asynchronous, synchronized here)
//   o_m2/m1/m0   - multiplier select to the ADPLL
//   o_pll_reset  - reset to the ADPLL
//   o_locked     - lock confirmed at o_cur_mult
//   o_cur_mult   - multiplier currently applied
//   o_done       - pulse: request completed with lock
//   o_fail       - pulse: all attempts for a request exhausted
//   o_loss       - pulse: lock lost while running
module adpll_ctrl
  import adpll_ctrl_pkg::*;
#(
  parameter int                RST_CYCLES   = 8,
  parameter int                LOCK_TIMEOUT = 1024,
  parameter int                LOCK_STABLE  = 16,
  parameter int                MAX_RETRY    = 3,
  parameter logic [MULT_W-1:0] DEFAULT_MULT = DEFAULT_MULT_CODE
) (
  input  logic              i_ref_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  input  logic [MULT_W-1:0] i_req_mult,
  output logic              o_req_ready,
  input  logic              i_lock,
  output logic              o_m2,
  output logic              o_m1,
  output logic              o_m0,
  output logic              o_pll_reset,
  output logic              o_locked,
  output logic [MULT_W-1:0] o_cur_mult,
  output logic              o_done,
  output logic              o_fail,
  output logic              o_loss
);

  localparam int RST_W   = cntWidth(RST_CYCLES);
  localparam int TO_W    = cntWidth(LOCK_TIMEOUT);
  localparam int STAB_W  = cntWidth(LOCK_STABLE);
  localparam int RETRY_W = cntWidth(MAX_RETRY);

  localparam logic [RST_W-1:0]   RST_LAST  = RST_W'(RST_CYCLES - 1);
  localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [TO_W-1:0]    TO_TERM   = TO_W'(LOCK_TIMEOUT);
  localparam logic [STAB_W-1:0]  STAB_TERM = STAB_W'(LOCK_STABLE);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  state_t              r_state;
  logic [RST_W-1:0]    r_rst_cnt;
  logic [TO_W-1:0]     r_to_cnt;
  logic [STAB_W-1:0]   r_stab_cnt;
  logic [RETRY_W-1:0]  r_retry;
  logic [MULT_W-1:0]   r_mult;
  logic                r_pll_reset;
  logic                r_ready;
  logic                r_locked;
  logic                r_done;
  logic                r_fail;
  logic                r_loss;

  logic                w_lock_s;
  logic                w_accept;
  logic                w_timeout;
  logic [TO_W-1:0]     w_to_next;
  logic [STAB_W-1:0]   w_stab_next;
  logic [RETRY_W-1:0]  w_retry_next;
  logic                w_confirm_done;
  logic                w_do_retry;

  adpll_ctrl_lock_sync u_lock_sync (
    .i_clk   (i_ref_clk),
    .i_rst   (i_reset),
    .i_async (i_lock),
    .o_sync  (w_lock_s)
  );

  assign w_accept     = i_req_valid && r_ready;
  assign w_timeout    = (r_to_cnt >= TO_LAST);
  // Both counters hold at their terminal count instead of wrapping.
  assign w_to_next    = (r_to_cnt == TO_TERM) ? r_to_cnt : r_to_cnt + 1'b1;
  assign w_stab_next  = (r_stab_cnt == STAB_TERM) ? r_stab_cnt : r_stab_cnt + 1'b1;
  assign w_retry_next = r_retry + 1'b1;

  // A confirmation that completes on the timeout cycle counts as a lock.
  // In WAIT_LOCK the timeout always wins.
  assign w_confirm_done = (r_state == ST_CONFIRM) && w_lock_s && (w_stab_next == STAB_TERM);
  assign w_do_retry     = w_timeout &&
                          ((r_state == ST_WAIT_LOCK) ||
                           ((r_state == ST_CONFIRM) && !w_confirm_done));

  // Sequencer. State, counters and all outputs are registered here.
  // Every path back to APPLY raises PLL reset and drops ready/locked on
  // the same edge. The event pulses are cleared by default and last one cycle.
  always_ff @(posedge i_ref_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= ST_APPLY;
      r_rst_cnt   <= '0;
      r_to_cnt    <= '0;
      r_stab_cnt  <= '0;
      r_retry     <= '0;
      r_mult      <= DEFAULT_MULT;
      r_pll_reset <= 1'b1;
      r_ready     <= 1'b0;
      r_locked    <= 1'b0;
      r_done      <= 1'b0;
      r_fail      <= 1'b0;
      r_loss      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_fail <= 1'b0;
      r_loss <= 1'b0;
      if (w_do_retry) begin
        r_stab_cnt  <= '0;
        r_pll_reset <= 1'b1;
        if (w_retry_next < RETRY_MAX) begin
          r_retry   <= w_retry_next;
          r_rst_cnt <= '0;
          r_state   <= ST_APPLY;
        end else begin
          r_retry  <= '0;
          r_state  <= ST_FAULT;
          r_ready  <= 1'b1;
          r_locked <= 1'b0;
          r_fail   <= 1'b1;
        end
      end else begin
        case (r_state)
          ST_APPLY: begin
            r_to_cnt   <= '0;
            r_stab_cnt <= '0;
            if (r_rst_cnt == RST_LAST) begin
              r_pll_reset <= 1'b0;
              r_state     <= ST_WAIT_LOCK;
            end else begin
              r_rst_cnt <= r_rst_cnt + 1'b1;
            end
          end
          ST_WAIT_LOCK: begin
            r_to_cnt <= w_to_next;
            if (w_lock_s) begin
              r_stab_cnt <= '0;
              r_state    <= ST_CONFIRM;
            end
          end
          ST_CONFIRM: begin
            r_to_cnt <= w_to_next;
            if (w_confirm_done) begin
              r_stab_cnt <= w_stab_next;
              r_state    <= ST_RUN;
              r_locked   <= 1'b1;
              r_ready    <= 1'b1;
              r_done     <= 1'b1;
            end else if (w_lock_s) begin
              r_stab_cnt <= w_stab_next;
            end else begin
              r_stab_cnt <= '0;
              r_state    <= ST_WAIT_LOCK;
            end
          end
          ST_RUN: begin
            // A request for the multiplier already locked completes at once.
            // Any other request, or a lock loss, forces a relock.
            // When both happen on the same edge, the request supplies the multiplier.
            if (w_accept && (i_req_mult == r_mult) && w_lock_s) begin
              r_done <= 1'b1;
            end else if (w_accept || !w_lock_s) begin
              r_loss      <= !w_lock_s;
              if (w_accept) begin
                r_mult <= i_req_mult;
              end
              r_retry     <= '0;
              r_rst_cnt   <= '0;
              r_pll_reset <= 1'b1;
              r_ready     <= 1'b0;
              r_locked    <= 1'b0;
              r_state     <= ST_APPLY;
            end
          end
          ST_FAULT: begin
            if (w_accept) begin
              r_mult      <= i_req_mult;
              r_retry     <= '0;
              r_rst_cnt   <= '0;
              r_pll_reset <= 1'b1;
              r_ready     <= 1'b0;
              r_locked    <= 1'b0;
              r_state     <= ST_APPLY;
            end
          end
          default: begin
            r_rst_cnt   <= '0;
            r_pll_reset <= 1'b1;
            r_ready     <= 1'b0;
            r_locked    <= 1'b0;
            r_state     <= ST_APPLY;
          end
        endcase
      end
    end
  end

  assign {o_m2, o_m1, o_m0} = r_mult;
  assign o_cur_mult  = r_mult;
  assign o_pll_reset = r_pll_reset;
  assign o_req_ready = r_ready;
  assign o_locked    = r_locked;
  assign o_done      = r_done;
  assign o_fail      = r_fail;
  assign o_loss      = r_loss;

endmodule
